modexp_ctrl: RTL
================

Name: modexp_ctrl

Overview:
- Sequential modular-exponentiation controller for the RSA encrypt/decrypt path.
- Computes result = base^exp mod n using right-to-left square-and-multiply.
- Time-shares one instance of the team's combinational 16-bit divider (Division16, WIDTH=2*W), using only its remainder output as the mod-n reducer.
- Sits between the key/message registers and the cipher output register; one operation in flight at a time.

Parameters:
W, 8, operand/modulus width; 2*W must equal the divider's WIDTH (16).
EW, 8, exponent width; fixes the number of square-and-multiply iterations.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
base  in  W  message/ciphertext operand; sampled with start.
exp  in  EW  exponent (e or d); sampled with start.
n  in  W  modulus; sampled with start.
busy  out  1  high in every state except IDLE.
done  out  1  registered one-cycle pulse; result/err valid from that cycle onward.
result  out  W  final residue; held until the next accepted start.
err  out  1  set with done when n==0; cleared on the next accepted start.

Behaviour:
- Reset is asynchronous and active-low and applies regardless of state, including mid-operation: state=IDLE, busy=0, done=0, result=0, err=0, internal regs=0.
- States: IDLE, REDUCE, MUL, SQR, DONE.
- Divider sharing: one divider instance.
  - Dividend mux, 2*W bits, zero-extended: REDUCE={0,base_r}; MUL=res_r*b_r; SQR=b_r*b_r.
  - Divisor = {W'b0, n_r}.
  - Remainder low W bits feed the registers; the quotient is unused.
- Products are full 2*W-bit unsigned. Operands are always < n_r, so nothing overflows.
- IDLE, start=1 with n!=0:
  - Capture base_r, exp_r, n_r; set res_r = (n==1) ? 0 : 1; clear err; go to REDUCE.
- IDLE, start=1 with n==0:
  - Capture nothing; go to DONE with err=1 and result=0.
  - The divider output is never used in this case.
- REDUCE: b_r <= base_r mod n_r; bit counter=0; go to MUL. One cycle.
- MUL:
  - If exp_r[0]=1: res_r <= res_r*b_r mod n_r; else hold res_r.
  - Go to SQR. One cycle.
- SQR:
  - b_r <= b_r*b_r mod n_r; exp_r >>= 1; counter++.
  - If counter reaches EW-1 before the increment, go to DONE; else go to MUL. One cycle.
- Iteration count: all EW bits are always processed, including leading zeros.
- Latency is fixed and data-independent:
  - With start high at edge k, the last SQR completes at edge k+2*EW+1.
  - done=1 and result valid in the cycle after that edge.
  - busy is high for 2*EW+2 cycles; 18 for EW=8.
- DONE: done=1, result<=res_r, busy=1; next edge returns to IDLE.
- start during busy (including DONE) is ignored, with no queuing.
- start at the same edge DONE->IDLE is also ignored; the earliest new acceptance is the first IDLE cycle.
- exp==0: result = 1 mod n (0 when n==1), after the full latency.

Optional Feature:
Macro MODEXP_CYCCNT_EN.
- Defined:
  - Adds output cyc_cnt [7:0], reset 0.
  - Counts cycles with busy=1 for the current operation; cleared on an accepted start; frozen in IDLE.
  - Reads 2*EW+2 after a normal op and 1 after an n==0 op.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- base=5, exp=3, n=13, start pulse -> busy 18 cycles; done one cycle; result=8, err=0.
- base=20, exp=2, n=7 (base>n) -> result=1; base=7, exp=10, n=11 -> result=1; base=3, exp=0, n=7 -> result=1.
- n=1, base=9, exp=5 -> result=0 after full latency; n=0 -> done the cycle after start, err=1, result=0, busy 1 cycle.
- Second start pulsed during MUL of the first op (base=2, exp=8, n=255) -> ignored; only one done; result=1 (256 mod 255); the first op's inputs are unaffected.
- rst_n low mid-SQR -> busy/done/result/err=0 immediately (asynchronous); after release, a fresh op base=5, exp=3, n=13 -> result=8.
- MODEXP_CYCCNT_EN defined -> cyc_cnt=18 after a normal op and 1 after an n=0 op; without the macro, the build has no cyc_cnt port.

Source files
------------

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modexp_ctrl (with helper division16)
// Summary  : Sequential modular exponentiation, result = base^exp mod n,
//            right-to-left square-and-multiply over all EW exponent bits.
//            A single combinational divider is time-shared as the mod-n
//            reducer; only its remainder is consumed.
// Options  : MODEXP_CYCCNT_EN - adds cyc_cnt[7:0], the busy-cycle count of
//            the current/last operation.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// division16: combinational unsigned divider. A zero divisor returns an
// all-ones quotient and passes the dividend through as the remainder, so the
// outputs stay defined even when the controller is not using them.
// ----------------------------------------------------------------------------
module division16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // Pure combinational divide with a defined zero-divisor result
  always_comb begin
    quotient  = '1;
    remainder = dividend;
    if (divisor != '0) begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// ----------------------------------------------------------------------------
// modexp_ctrl: controller top
// ----------------------------------------------------------------------------
module modexp_ctrl #(
  parameter int W  = 8,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          err
`ifdef MODEXP_CYCCNT_EN
  ,
  output logic [7:0]    cyc_cnt
`endif
);

  // Counter only has to reach EW-1; keep at least one bit for EW==1
  localparam int CW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_MUL    = 3'd2,
    S_SQR    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  base_q,   base_d;
  logic [EW-1:0] exp_q,    exp_d;
  logic [W-1:0]  n_q,      n_d;
  logic [W-1:0]  res_q,    res_d;
  logic [W-1:0]  b_q,      b_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          err_q,    err_d;
  logic          done_q,   done_d;

  // Shared divider plumbing
  logic [2*W-1:0] div_dividend;
  logic [2*W-1:0] div_divisor;
  logic [2*W-1:0] div_rem;
  logic [2*W-1:0] div_quot_unused;
  logic [W-1:0]   rem_hi_unused;
  logic [W-1:0]   rem_lo;
  logic [2*W-1:0] prod_mul;
  logic [2*W-1:0] prod_sqr;

  // Full-width products; operands are already reduced below n_q
  assign prod_mul = {{W{1'b0}}, res_q} * {{W{1'b0}}, b_q};
  assign prod_sqr = {{W{1'b0}}, b_q} * {{W{1'b0}}, b_q};

  // Dividend select: which value is being reduced this cycle
  always_comb begin
    div_dividend = '0;
    case (state_q)
      S_REDUCE: div_dividend = {{W{1'b0}}, base_q};
      S_MUL:    div_dividend = prod_mul;
      S_SQR:    div_dividend = prod_sqr;
      default:  div_dividend = '0;
    endcase
  end

  assign div_divisor = {{W{1'b0}}, n_q};

  division16 #(
    .WIDTH (2*W)
  ) u_div (
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quot_unused),
    .remainder (div_rem)
  );

  // The residue always fits in W bits since the divisor is W bits wide
  assign {rem_hi_unused, rem_lo} = div_rem;

  // Next-state and datapath update for the square-and-multiply sequence
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    n_d      = n_q;
    res_d    = res_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n == '0) begin
            // Degenerate modulus: report an error without touching operands
            err_d    = 1'b1;
            result_d = '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            base_d  = base;
            exp_d   = exp;
            n_d     = n;
            // Anything mod 1 is 0, so the accumulator starts at 1 mod n
            res_d   = (n == W'(1)) ? '0 : W'(1);
            err_d   = 1'b0;
            state_d = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        b_d     = rem_lo;
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (exp_q[0]) begin
          res_d = rem_lo;
        end
        state_d = S_SQR;
      end
      S_SQR: begin
        b_d   = rem_lo;
        exp_d = exp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // res_q is final: SQR never modifies the accumulator
          result_d = res_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      res_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      res_q    <= res_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

`ifdef MODEXP_CYCCNT_EN
  logic [7:0] cyc_cnt_q, cyc_cnt_d;

  // Busy-cycle count: restart at 1 on acceptance, bump on each busy->busy edge
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        cyc_cnt_d = 8'd1;
      end
    end else if (state_d != S_IDLE) begin
      cyc_cnt_d = cyc_cnt_q + 8'd1;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= 8'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

`default_nettype wire
